// File: rtl/matrix_add_row_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// matrix_add_row_sequencer_pkg
//
// Shared definitions for the matrix-add row sequencer and the logic around it:
//   - seq_state_t  : sequencer FSM states
//   - ROWS_DEFAULT : default number of rows per matrix operation
//   - VEC_LANES    : lane count of the shared vector adder, so the top level
//                    and the adder instance agree on the datapath width
//   - addr_width() : row address width for a given row count (never below 1)
// -----------------------------------------------------------------------------
package matrix_add_row_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int ROWS_DEFAULT = 10;
    localparam int VEC_LANES    = 12;

    // A single-row matrix still needs a one-bit address port.
    function automatic int addr_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/matrix_add_row_sequencer_seq_valid_delay.sv
// -----------------------------------------------------------------------------
// seq_valid_delay
//
// Enable-gated shift register that delays a valid strobe by LATENCY enabled
// clock cycles. With LATENCY = 0 the strobe passes straight through.
// Used to line up the adder's inReady with operand data returning from the
// A/B memories, and reusable anywhere a memory latency must be modelled.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset, clears the delay line
//   enable    in   clock enable; low freezes the delay line
//   valid_in  in   strobe to delay
//   valid_out out  strobe delayed by LATENCY enabled cycles
// -----------------------------------------------------------------------------
module seq_valid_delay #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic valid_in,
    output logic valid_out
);

    generate
        if (LATENCY == 0) begin : g_bypass
            // Clock, reset and enable have no job when there is no delay.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ reset ^ enable;
            assign valid_out   = valid_in;
        end else begin : g_shift
            logic [LATENCY-1:0] pipe;

            // The newest strobe enters at bit 0 and leaves from the top bit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pipe <= '0;
                end else if (enable) begin
                    pipe <= (pipe << 1) | LATENCY'(valid_in);
                end
            end

            assign valid_out = pipe[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/matrix_add_row_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_add_row_sequencer
//
// Feeds one shared registered vector adder one matrix row per cycle. It issues
// operand row reads, raises the adder's inReady once the operand data is
// valid, and writes each result row back as the adder reports outReady.
// Completion is a single-cycle done pulse.
//
// Parameters:
//   ROWS        rows per matrix operation (>= 1)
//   MEM_LATENCY cycles from rdEn to operand data at the adder inputs (>= 0)
//   ADDR_W      row address width
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   global clock enable shared with the adder
//   start        in   single-cycle request to begin an operation
//   rdEn         out  operand memory read strobe
//   rdAddr       out  operand row address
//   vecInReady   out  adder inReady
//   vecOutReady  in   adder outReady
//   wrEn         out  result memory write strobe
//   wrAddr       out  result row address
//   busy         out  operation in progress
//   done         out  one-cycle completion pulse
//   errFlag      out  sticky stray-outReady flag (SEQ_ERR_CHECK_EN only)
//
// Build option: define SEQ_ERR_CHECK_EN to add errFlag.
// -----------------------------------------------------------------------------
module matrix_add_row_sequencer
    import matrix_add_row_sequencer_pkg::*;
#(
    parameter int ROWS        = ROWS_DEFAULT,
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = addr_width(ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    output logic              rdEn,
    output logic [ADDR_W-1:0] rdAddr,
    output logic              vecInReady,
    input  logic              vecOutReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic              busy,
    output logic              done
`ifdef SEQ_ERR_CHECK_EN
    ,
    output logic              errFlag
`endif
);

    // One extra bit lets the write count reach ROWS without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  ROWS_CNT = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ROWS - 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  wr_cnt_next;
    logic              in_flight;
    logic              accept_write;
    logic              all_written;

    // State and counters only move on enabled cycles, so a stalled enable
    // freezes the whole operation in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_cnt  <= '0;
        end else if (enable) begin
            state   <= next_state;
            rd_addr <= rd_addr_next;
            wr_addr <= wr_addr_next;
            wr_cnt  <= wr_cnt_next;
        end
    end

    // Next-state and outputs. A returned outReady is only taken as a write
    // while an operation is in flight and fewer than ROWS rows are stored;
    // anything else is dropped. The write in the current cycle already counts
    // towards completion so done follows the last write by one cycle.
    always_comb begin
        next_state   = state;
        rd_addr_next = rd_addr;
        wr_addr_next = wr_addr;
        wr_cnt_next  = wr_cnt;
        rdEn         = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        in_flight    = (state == ISSUE) || (state == DRAIN);
        accept_write = in_flight && vecOutReady && (wr_cnt != ROWS_CNT);
        wrEn         = enable && accept_write;
        all_written  = (wr_cnt == ROWS_CNT) || (accept_write && (wr_cnt == LAST_CNT));

        if (accept_write) begin
            wr_cnt_next = wr_cnt + CNT_W'(1);
            if (wr_addr != LAST_ROW) begin
                wr_addr_next = wr_addr + ADDR_W'(1);
            end
        end

        case (state)
            IDLE: begin
                rd_addr_next = '0;
                wr_addr_next = '0;
                wr_cnt_next  = '0;
                if (start) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                rdEn = 1'b1;
                busy = 1'b1;
                if (all_written) begin
                    next_state = DONE;
                end else if (rd_addr == LAST_ROW) begin
                    next_state = DRAIN;
                end
                if (rd_addr != LAST_ROW) begin
                    rd_addr_next = rd_addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (all_written) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                rd_addr_next = '0;
                wr_addr_next = '0;
                wr_cnt_next  = '0;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign rdAddr = rd_addr;
    assign wrAddr = wr_addr;

    seq_valid_delay #(
        .LATENCY(MEM_LATENCY)
    ) u_valid_delay (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .valid_in (rdEn),
        .valid_out(vecInReady)
    );

`ifdef SEQ_ERR_CHECK_EN
    logic stray_pulse;

    // Any outReady that is not taken as a write is a stray. A stray in the
    // same cycle as an accepted start still sets the flag so it is not lost.
    assign stray_pulse = vecOutReady && !accept_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errFlag <= 1'b0;
        end else if (enable) begin
            if (stray_pulse) begin
                errFlag <= 1'b1;
            end else if ((state == IDLE) && start) begin
                errFlag <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/matrix_add_row_sequencer.md
Name: matrix_add_row_sequencer

Overview:
- Sequences one shared 12-lane registered vector adder to add two ROWS-row matrices, one row per cycle.
- Issues row read addresses to the A/B operand memories and drives the adder's inReady, aligned to the memory read latency.
- Counts the adder's outReady pulses, drives result write address/enable, and signals completion.
- Sits between the matrix-add top level and the vector adder instance plus its operand and result RAMs.

Parameters:
- ROWS, 10, rows per matrix operation; must be >= 1.
- MEM_LATENCY, 1, cycles from rdEn to operand data valid at the adder inputs; must be >= 0.
- ADDR_W, $clog2(ROWS) (min 1), row address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global clock enable; low freezes all state (shared with the adder).
- start  input  1  single-cycle request to begin an operation.
- rdEn  output  1  operand memory read strobe.
- rdAddr  output  ADDR_W  operand row address.
- vecInReady  output  1  to the adder inReady.
- vecOutReady  input  1  from the adder outReady.
- wrEn  output  1  result memory write strobe (combinational: vecOutReady while in ISSUE/DRAIN).
- wrAddr  output  ADDR_W  result row address.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release): state IDLE; rdEn, vecInReady, wrEn, busy and done = 0; rdAddr and wrAddr = 0; delay line cleared.
- enable low: no register updates; wrEn forced 0; all other outputs hold their values.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with enable=1 -> ISSUE.
  - rdAddr and wrAddr reset to 0.
  - vecOutReady is ignored.
- ISSUE:
  - rdEn=1 every enabled cycle; rdAddr runs 0..ROWS-1.
  - After the rdAddr=ROWS-1 cycle -> DRAIN.
- vecInReady:
  - Equals rdEn delayed by MEM_LATENCY enabled cycles through a shift register.
  - MEM_LATENCY=0 means vecInReady = rdEn.
- Write side:
  - Each vecOutReady=1 with enable=1 in ISSUE/DRAIN gives wrEn=1 at the current wrAddr.
  - wrAddr increments after each write.
  - The adder latency needs no parameter, because writes are driven only by returned outReady.
- DRAIN:
  - rdEn=0.
  - Waits until ROWS writes are counted, then -> DONE.
  - If the ROWS-th write occurs while still in ISSUE (only possible for ROWS=1 with zero latency), the state goes straight to DONE.
- DONE: done=1 for one cycle, busy falls the same cycle, then -> IDLE.
- Timing: start sampled at edge 0, so rdEn is high for cycles 1..ROWS. With MEM_LATENCY=1 and a 1-cycle adder:
  - vecInReady is high for cycles 2..ROWS+1.
  - wrEn is high for cycles 3..ROWS+2.
  - done is high at cycle ROWS+3.
- start while busy: ignored, no queueing.
- start in the DONE cycle: ignored.
- Counters never wrap mid-operation. The write counter saturates at ROWS, so extra outReady pulses after ROWS writes are dropped.
- Reset mid-operation: immediate return to IDLE, in-flight rows discarded, no done pulse.

Optional Feature:
- Macro: SEQ_ERR_CHECK_EN.
- Defined:
  - Adds output errFlag (1 bit, reset 0).
  - errFlag is sticky-set when vecOutReady=1 in IDLE or DONE, or after ROWS writes are already counted.
  - errFlag is cleared only by reset or an accepted start.
- Undefined: port absent, and such pulses are silently ignored as above.

Decomposition:
- Shared package holds:
  - State enum {IDLE, ISSUE, DRAIN, DONE}.
  - ROWS default and ADDR_W helper function.
  - Lane-count constant (12), so the top level and adder instance agree.
- One natural sub-module, seq_valid_delay:
  - MEM_LATENCY-deep enable-gated shift register producing vecInReady.
  - Reused to model or align memory latency elsewhere.

Test Plan:
- Nominal: ROWS=10, MEM_LATENCY=1, 1-cycle adder model, start at cycle 0 -> rdAddr 0..9 at cycles 1..10, wrAddr 0..9 with wrEn at cycles 3..12, done at cycle 13, busy high for cycles 1..12.
- Enable stall: enable=0 for cycles 5..7 -> every output frozen for 3 cycles, done moves to cycle 16, no duplicated or skipped address.
- Start while busy: second start at cycle 4 -> ignored, exactly 10 writes, exactly one done.
- Async reset at cycle 6 -> outputs 0 immediately, no done; a new start afterwards runs a clean 0..9 sequence.
- MEM_LATENCY=0, ROWS=1 -> rdEn and vecInReady at cycle 1, wrEn at cycle 2, done at cycle 3.
- SEQ_ERR_CHECK_EN defined: vecOutReady pulse in IDLE -> errFlag=1 and held until the next start, wrEn stays 0.
